// File: rtl/reg_scan_display.sv
// Register-file scanner: settles on an address, captures the read data and
// shows the low 24 data bits plus the 5-bit address on eight 7-segment digits.
module reg_scan_display #(
  parameter int unsigned SCAN_PERIOD   = 50000000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        autoMode,
  input  logic [4:0]  manualAddr,
  input  logic        hold,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [55:0] hexOut,
  output logic        dataChanged
);

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned HEX_W    = 56;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DWELL_W  = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    DWELL   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_reg, addr_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
  logic [DATA_W-1:0]   data_reg, data_nxt;
  logic                changed_nxt;
  logic [HEX_W-1:0]    hex_nxt;
  logic                settle_last;
  logic                dwell_last;
  logic                frozen;

  assign settle_last = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign dwell_last  = (dwell_cnt == DWELL_W'(SCAN_PERIOD - 1));
  assign frozen      = (state == DWELL) && hold;
  assign regAddr     = addr_reg;

  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  // Next-state logic; mode and address inputs only matter in DWELL
  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE:  if (settle_last) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DWELL;
      DWELL: begin
        if (!hold) begin
          if (autoMode) begin
            if (dwell_last) state_nxt = SETTLE;
          end else if (manualAddr != addr_reg) begin
            state_nxt = SETTLE;
          end else begin
            state_nxt = CAPTURE;
          end
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  // Datapath next values per state
  always_comb begin
    addr_nxt    = addr_reg;
    settle_nxt  = settle_cnt;
    dwell_nxt   = dwell_cnt;
    data_nxt    = data_reg;
    changed_nxt = 1'b0;
    case (state)
      SETTLE: begin
        if (!settle_last) settle_nxt = settle_cnt + SETTLE_W'(1);
      end
      CAPTURE: begin
        data_nxt    = regData;
        changed_nxt = (regData != data_reg);
        dwell_nxt   = '0;
      end
      DWELL: begin
        if (!hold) begin
          if (autoMode) begin
            if (dwell_last) begin
              addr_nxt   = addr_reg + ADDR_W'(1);
              settle_nxt = '0;
            end else begin
              dwell_nxt = dwell_cnt + DWELL_W'(1);
            end
          end else if (manualAddr != addr_reg) begin
            addr_nxt   = manualAddr;
            settle_nxt = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Display encoding; frozen while held so the digits cannot shift under hold
  always_comb begin
    hex_nxt = hexOut;
    if (!frozen) begin
      for (int i = 0; i < 6; i++) begin
        hex_nxt[SEG_W*i +: SEG_W] = seg7(data_reg[4*i +: 4]);
      end
      hex_nxt[SEG_W*6 +: SEG_W] = seg7(addr_reg[3:0]);
      hex_nxt[SEG_W*7 +: SEG_W] = seg7({3'b000, addr_reg[4]});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      settle_cnt  <= '0;
      dwell_cnt   <= '0;
      data_reg    <= '0;
      dataChanged <= 1'b0;
      hexOut      <= {HEX_W{1'b1}};
    end else begin
      addr_reg    <= addr_nxt;
      settle_cnt  <= settle_nxt;
      dwell_cnt   <= dwell_nxt;
      data_reg    <= data_nxt;
      dataChanged <= changed_nxt;
      hexOut      <= hex_nxt;
    end
  end

endmodule

// File: tb/tb_reg_scan_display.sv
// Directed bench for reg_scan_display with SCAN_PERIOD=4, SETTLE_CYCLES=2.
module tb_reg_scan_display;

  logic        clk;
  logic        rst_n;
  logic        auto_mode;
  logic [4:0]  manual_addr;
  logic        hold;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [55:0] hex_out;
  logic        data_changed;

  logic [31:0] reg_file [32];
  logic [6:0]  seg_tab [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic        chg;
    logic [23:0] hdata;
    logic [4:0]  haddr;
  } vec_t;

  vec_t vecs [16];

  reg_scan_display #(.SCAN_PERIOD(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .autoMode(auto_mode),
    .manualAddr(manual_addr),
    .hold(hold),
    .regAddr(reg_addr),
    .regData(reg_data),
    .hexOut(hex_out),
    .dataChanged(data_changed)
  );

  assign reg_data = reg_file[reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] mk_hex(input logic [23:0] d, input logic [4:0] a);
    logic [55:0] h;
    for (int i = 0; i < 6; i++) h[7*i +: 7] = seg_tab[d[4*i +: 4]];
    h[42 +: 7] = seg_tab[a[3:0]];
    h[49 +: 7] = seg_tab[{3'b000, a[4]}];
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [55:0] held_hex;
    int pulses;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int k = 0; k < 32; k++) reg_file[k] = 32'h100 + 32'(k);

    // Edge-by-edge expectations after reset release: {regAddr, dataChanged, shown data, shown addr}
    vecs[0]  = '{5'd0, 1'b0, 24'h000000, 5'd0};
    vecs[1]  = '{5'd0, 1'b0, 24'h000000, 5'd0};
    vecs[2]  = '{5'd0, 1'b1, 24'h000000, 5'd0};
    vecs[3]  = '{5'd0, 1'b0, 24'h000100, 5'd0};
    vecs[4]  = '{5'd0, 1'b0, 24'h000100, 5'd0};
    vecs[5]  = '{5'd0, 1'b0, 24'h000100, 5'd0};
    vecs[6]  = '{5'd1, 1'b0, 24'h000100, 5'd0};
    vecs[7]  = '{5'd1, 1'b0, 24'h000100, 5'd1};
    vecs[8]  = '{5'd1, 1'b0, 24'h000100, 5'd1};
    vecs[9]  = '{5'd1, 1'b1, 24'h000100, 5'd1};
    vecs[10] = '{5'd1, 1'b0, 24'h000101, 5'd1};
    vecs[11] = '{5'd1, 1'b0, 24'h000101, 5'd1};
    vecs[12] = '{5'd1, 1'b0, 24'h000101, 5'd1};
    vecs[13] = '{5'd2, 1'b0, 24'h000101, 5'd1};
    vecs[14] = '{5'd2, 1'b0, 24'h000101, 5'd2};
    vecs[15] = '{5'd2, 1'b0, 24'h000101, 5'd2};

    rst_n = 1'b0;
    auto_mode = 1'b1;
    manual_addr = 5'd0;
    hold = 1'b0;
    step(2);
    chk("reset_hex", 64'(hex_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("reset_addr", 64'(reg_addr), 64'd0);
    chk("reset_chg", 64'(data_changed), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(1);
      chk($sformatf("vec%0d_addr", i), 64'(reg_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_chg", i), 64'(data_changed), 64'(vecs[i].chg));
      chk($sformatf("vec%0d_hex", i), 64'(hex_out), 64'(mk_hex(vecs[i].hdata, vecs[i].haddr)));
    end

    // Auto scan steps every 7 edges through 31 and wraps to 0
    for (int k = 3; k <= 32; k++) begin
      step((k == 3) ? 5 : 7);
      chk($sformatf("scan_addr%0d", k), 64'(reg_addr), 64'(k % 32));
      if (k == 6) chk("addr5_hex", 64'(hex_out), 64'(mk_hex(24'h000105, 5'd5)));
      if (k == 32) chk("wrap_digit7_before", 64'(hex_out[55:49]), 64'h79);
    end
    step(1);
    chk("wrap_digit7_after", 64'(hex_out[55:49]), 64'h40);

    // Hold for 20 edges in DWELL at addr 0 with dwell count 2
    step(4);
    chk("pre_hold_addr", 64'(reg_addr), 64'd0);
    held_hex = hex_out;
    chk("pre_hold_hex", 64'(hex_out), 64'(mk_hex(24'h000100, 5'd0)));
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk($sformatf("hold%0d_addr", i), 64'(reg_addr), 64'd0);
      chk($sformatf("hold%0d_hex", i), 64'(hex_out), 64'(held_hex));
    end
    hold = 1'b0;
    step(1);
    chk("resume_addr_still0", 64'(reg_addr), 64'd0);
    step(1);
    chk("resume_addr1", 64'(reg_addr), 64'd1);

    // Manual address change during SETTLE waits for DWELL; capture still completes
    auto_mode = 1'b0;
    manual_addr = 5'd3;
    reg_file[3] = 32'hA;
    step(2);
    chk("settle_ignore_addr", 64'(reg_addr), 64'd1);
    step(1);
    chk("settle_capture_chg", 64'(data_changed), 64'd1);
    chk("settle_capture_addr", 64'(reg_addr), 64'd1);
    step(1);
    chk("manual_addr3", 64'(reg_addr), 64'd3);
    step(3);
    chk("manual_first_chg", 64'(data_changed), 64'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (data_changed) pulses++;
    end
    chk("refresh_no_pulse", 64'(pulses), 64'd0);
    chk("digit0_A", 64'(hex_out[6:0]), 64'h08);
    reg_file[3] = 32'hB;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (data_changed) pulses++;
    end
    chk("change_one_pulse", 64'(pulses), 64'd1);
    chk("digit0_b", 64'(hex_out[6:0]), 64'h03);

    // Reset during DWELL at addr 9
    auto_mode = 1'b1;
    for (int i = 0; i < 400 && reg_addr != 5'd9; i++) step(1);
    chk("reach_addr9", 64'(reg_addr), 64'd9);
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("midreset_hex", 64'(hex_out), 64'h00FF_FFFF_FFFF_FFFF);
    chk("midreset_addr", 64'(reg_addr), 64'd0);
    chk("midreset_chg", 64'(data_changed), 64'd0);
    rst_n = 1'b1;
    step(2);
    chk("post_reset_no_early_cap", 64'(data_changed), 64'd0);
    step(1);
    chk("post_reset_cap", 64'(data_changed), 64'd1);
    chk("post_reset_addr", 64'(reg_addr), 64'd0);
    step(1);
    chk("post_reset_hex", 64'(hex_out), 64'(mk_hex(24'h000100, 5'd0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
